// File: rtl/spi_boot_loader.sv
// SPI boot master: streams (address, data) words into PULPino memory as single-lane SPI
// write frames (cmd, addr, data; MSB first, mode 0) and then raises fetch_enable_o.
module spi_boot_loader #(
  parameter int unsigned CLK_DIV       = 2,
  parameter logic [7:0]  SPI_CMD_WRITE = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic [31:0] word_addr_i,
  input  logic [31:0] word_data_i,
  input  logic        word_last_i,
  output logic        spi_clk_o,
  output logic        spi_cs_o,
  output logic        spi_sdo_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        fetch_enable_o
);

  localparam int unsigned     DivW   = $clog2(CLK_DIV + 1);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [6:0]      BitMax = 7'd71;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCsSetup,
    StShift,
    StCsHold,
    StGap,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [6:0]      bit_q, bit_d;
  logic            phase_q, phase_d;
  logic [71:0]     shreg_q, shreg_d;
  logic            last_q, last_d;
  logic            div_wrap;

  assign div_wrap = (div_q == DivMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      shreg_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
    end
  end

  // phase_q is the SCK-high half in SHIFT and the second half of the gap in GAP.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
        if (word_valid_i) begin
          shreg_d = {SPI_CMD_WRITE, word_addr_i, word_data_i};
          last_d  = word_last_i;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = StCsSetup;
        end
      end
      StCsSetup: begin
        if (div_wrap) begin
          div_d   = '0;
          state_d = StShift;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShift: begin
        if (div_wrap) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            shreg_d = {shreg_q[70:0], 1'b0};
            if (bit_q == BitMax) begin
              state_d = StCsHold;
            end else begin
              bit_d = bit_q + 7'd1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StCsHold: begin
        if (div_wrap) begin
          div_d   = '0;
          state_d = StGap;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if (div_wrap) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            state_d = last_q ? StDone : StLoad;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign word_ready_o   = (state_q == StLoad);
  assign spi_cs_o       = !(state_q == StCsSetup || state_q == StShift || state_q == StCsHold);
  assign spi_clk_o      = (state_q == StShift) && phase_q;
  assign spi_sdo_o      = (state_q == StCsSetup || state_q == StShift) && shreg_q[71];
  assign busy_o         = (state_q == StLoad) || (state_q == StCsSetup) || (state_q == StShift) ||
                          (state_q == StCsHold) || (state_q == StGap);
  assign done_o         = (state_q == StDone);
  assign fetch_enable_o = (state_q == StDone);

endmodule

// File: tb/tb_spi_boot_loader.sv
// Directed bench for spi_boot_loader: one instance at CLK_DIV=2, one at CLK_DIV=1,
// each with a small SPI frame monitor.
module tb_spi_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT A (CLK_DIV = 2) ----------------
  logic        rst, start, valid, last;
  logic [31:0] addr, data;
  logic        ready, sck, cs, sdo, busy, done, fe;

  spi_boot_loader #(.CLK_DIV(2), .SPI_CMD_WRITE(8'h02)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .word_valid_i  (valid),
    .word_ready_o  (ready),
    .word_addr_i   (addr),
    .word_data_i   (data),
    .word_last_i   (last),
    .spi_clk_o     (sck),
    .spi_cs_o      (cs),
    .spi_sdo_o     (sdo),
    .busy_o        (busy),
    .done_o        (done),
    .fetch_enable_o(fe)
  );

  logic [71:0] cap = '0;
  int          edges = 0;
  always @(posedge sck) begin
    cap   <= {cap[70:0], sdo};
    edges <= edges + 1;
  end

  logic [71:0] fr_q[$];
  int ed_q[$], win_q[$], gap_q[$], fall_q[$], rise_q[$];
  logic cs_prev = 1'b1, have_prev = 1'b0, got_rise = 1'b0;
  int win = 0, hi = 0, edge0 = 0;

  always @(negedge clk) begin
    if (!cs) begin
      if (cs_prev) begin
        fall_q.push_back(cyc);
        edge0 = edges;
        got_rise = 1'b0;
        if (have_prev) gap_q.push_back(hi);
      end
      win++;
      if (sck && !got_rise) begin
        rise_q.push_back(cyc);
        got_rise = 1'b1;
      end
    end else begin
      if (!cs_prev) begin
        win_q.push_back(win);
        fr_q.push_back(cap);
        ed_q.push_back(edges - edge0);
        win = 0;
        hi = 0;
        have_prev = 1'b1;
      end
      hi++;
    end
    if (rst) have_prev = 1'b0;
    cs_prev = cs;
  end

  // ---------------- DUT B (CLK_DIV = 1) ----------------
  logic        rst_b, start_b, valid_b, last_b;
  logic [31:0] addr_b, data_b;
  logic        ready_b, sck_b, cs_b, sdo_b, busy_b, done_b, fe_b;

  spi_boot_loader #(.CLK_DIV(1), .SPI_CMD_WRITE(8'h02)) u_dut_b (
    .clk           (clk),
    .rst           (rst_b),
    .start_i       (start_b),
    .word_valid_i  (valid_b),
    .word_ready_o  (ready_b),
    .word_addr_i   (addr_b),
    .word_data_i   (data_b),
    .word_last_i   (last_b),
    .spi_clk_o     (sck_b),
    .spi_cs_o      (cs_b),
    .spi_sdo_o     (sdo_b),
    .busy_o        (busy_b),
    .done_o        (done_b),
    .fetch_enable_o(fe_b)
  );

  logic [71:0] cap_b = '0;
  int          edges_b = 0;
  always @(posedge sck_b) begin
    cap_b   <= {cap_b[70:0], sdo_b};
    edges_b <= edges_b + 1;
  end

  logic [71:0] frb_q[$];
  int edb_q[$], winb_q[$], togb_q[$];
  logic csb_prev = 1'b1, sckb_prev = 1'b0;
  int winb = 0, togb = 0, edgeb0 = 0;

  always @(negedge clk) begin
    if (!cs_b) begin
      if (csb_prev) edgeb0 = edges_b;
      winb++;
      if (sck_b != sckb_prev) togb++;
    end else if (!csb_prev) begin
      winb_q.push_back(winb);
      togb_q.push_back(togb);
      frb_q.push_back(cap_b);
      edb_q.push_back(edges_b - edgeb0);
      winb = 0;
      togb = 0;
    end
    csb_prev  = cs_b;
    sckb_prev = sck_b;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] d, input logic l,
                           output int hs);
    int n = 0;
    valid = 1'b1;
    addr  = a;
    data  = d;
    last  = l;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_val("handshake_timeout", 72'(n < 2000), 72'd1);
    hs = cyc;
    @(negedge clk);
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_val("done_timeout", 72'(n < 2000), 72'd1);
    dc = cyc;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  localparam logic [71:0] FrameSingle = {8'h02, 32'h0000_0000, 32'hDEAD_BEEF};

  logic [31:0] a3[3] = '{32'h0010_0000, 32'h0010_0004, 32'h0010_0008};
  logic [31:0] d3[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

  initial begin
    int hs, hs2, dc, nf, nw, ng, nfall, nrise, n;
    int hs3[3];
    logic ok;

    rst_b = 1'b1; start_b = 1'b0; valid_b = 1'b0; last_b = 1'b0;
    addr_b = '0; data_b = '0;

    // Reset with random inputs
    rst = 1'b1;
    repeat (3) begin
      start = 1'($urandom); valid = 1'($urandom); last = 1'($urandom);
      addr = $urandom; data = $urandom;
      @(negedge clk);
    end
    check_val("reset_outputs", {ready, sck, cs, sdo, busy, done, fe}, 7'b0010000);
    start = 1'b0; valid = 1'b1; last = 1'b0;
    rst = 1'b0;
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      ok &= ({ready, sck, cs, sdo, busy, done, fe} == 7'b0010000);
    end
    check_val("idle_without_start", ok, 1'b1);
    valid = 1'b0;

    // Single word
    nf = fr_q.size(); nfall = fall_q.size(); nrise = rise_q.size(); nw = win_q.size();
    pulse_start();
    check_val("busy_in_load", {busy, ready}, 2'b11);
    send_word(32'h0000_0000, 32'hDEAD_BEEF, 1'b1, hs);
    valid = 1'b0;
    wait_done(dc);
    check_val("single_frame", fr_q[nf], FrameSingle);
    check_val("single_edges", ed_q[nf], 72'd72);
    check_val("single_cs_low", win_q[nw], 72'd292);
    check_val("single_cs_fall", fall_q[nfall] - hs, 72'd1);
    check_val("single_first_rise", rise_q[nrise] - hs, 72'd5);
    check_val("single_done_time", dc - hs, 72'd297);
    check_val("single_fetch_en", {fe, busy}, 2'b10);
    pulse_start();
    repeat (20) @(negedge clk);
    check_val("done_sticky", {done, fe, busy, cs}, 4'b1101);
    check_val("no_restart_after_done", fr_q.size() - nf, 72'd1);

    // Three words back-to-back
    do_reset();
    check_val("reset_clears_done", {done, fe}, 2'b00);
    nf = fr_q.size(); nw = win_q.size(); ng = gap_q.size();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send_word(a3[i], d3[i], (i == 2), hs3[i]);
      check_val("fe_low_during_load", fe, 1'b0);
    end
    valid = 1'b0;
    wait_done(dc);
    check_val("three_frame_count", fr_q.size() - nf, 72'd3);
    for (int i = 0; i < 3; i++) begin
      check_val("three_frame", fr_q[nf + i], {8'h02, a3[i], d3[i]});
      check_val("three_cs_low", win_q[nw + i], 72'd292);
    end
    // GAP (2*CLK_DIV) plus the single LOAD handshake cycle
    check_val("three_gap0", gap_q[ng], 72'd5);
    check_val("three_gap1", gap_q[ng + 1], 72'd5);
    check_val("three_hs_spacing0", hs3[1] - hs3[0], 72'd297);
    check_val("three_hs_spacing1", hs3[2] - hs3[1], 72'd297);
    check_val("three_done_time", dc - hs3[2], 72'd297);

    // Valid gap of 50 cycles between words
    do_reset();
    nf = fr_q.size(); nfall = fall_q.size();
    pulse_start();
    send_word(32'h0000_0100, 32'h0BAD_F00D, 1'b0, hs);
    valid = 1'b0;
    n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_val("stall_ready_timeout", 72'(n < 2000), 72'd1);
    ok = 1'b1;
    repeat (50) begin
      ok &= (ready && cs && !sck && busy);
      @(negedge clk);
    end
    check_val("stall_idle_bus", ok, 1'b1);
    send_word(32'h0000_0104, 32'hFEED_C0DE, 1'b1, hs2);
    valid = 1'b0;
    wait_done(dc);
    check_val("stall_cs_fall", fall_q[nfall + 1] - hs2, 72'd1);
    check_val("stall_frame", fr_q[nf + 1], {8'h02, 32'h0000_0104, 32'hFEED_C0DE});
    check_val("stall_done_time", dc - hs2, 72'd297);

    // Reset during bit 40 of the first word, then a clean reload
    do_reset();
    pulse_start();
    send_word(32'h0000_0200, 32'h1234_5678, 1'b0, hs);
    n = 0;
    while ((edges - edge0) < 40 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_val("bit40_timeout", 72'(n < 2000), 72'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_reset_outputs", {cs, sck, busy, ready, sdo}, 5'b10000);
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    nf = fr_q.size();
    pulse_start();
    send_word(32'h0000_0300, 32'hCAFE_F00D, 1'b1, hs);
    valid = 1'b0;
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done(dc);
    check_val("reload_frame_count", fr_q.size() - nf, 72'd1);
    check_val("reload_frame", fr_q[nf], {8'h02, 32'h0000_0300, 32'hCAFE_F00D});
    check_val("reload_done_time", dc - hs, 72'd297);

    // CLK_DIV = 1 instance
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    valid_b = 1'b1; addr_b = 32'h0000_0010; data_b = 32'hA5A5_A5A5; last_b = 1'b1;
    n = 0;
    while (!ready_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("b_handshake_timeout", 72'(n < 100), 72'd1);
    hs = cyc;
    @(negedge clk);
    valid_b = 1'b0;
    n = 0;
    while (!done_b && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_val("b_done_timeout", 72'(n < 1000), 72'd1);
    check_val("b_done_time", cyc - hs, 72'd149);
    check_val("b_frame", frb_q[0], {8'h02, 32'h0000_0010, 32'hA5A5_A5A5});
    check_val("b_edges", edb_q[0], 72'd72);
    check_val("b_cs_low", winb_q[0], 72'd146);
    check_val("b_sck_toggles", togb_q[0], 72'd144);
    check_val("b_fetch_en", fe_b, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
